lfsr_codec: RTL and testbench

LFSR_CODEC -- requirements
Module: lfsr_codec

---
 rtl/lfsr_pkg.sv | 20 ++
 rtl/lfsr_step.sv | 36 +++
 rtl/lfsr_codec.sv | 207 ++++++++++++++++++++
 tb/tb_lfsr_codec.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// lfsr_codec shared types
// FSM states and job mode encoding
package lfsr_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAD,
    S_XFER,
    S_FIN
  } state_e;

  typedef enum logic {
    ENC = 1'b0,
    DEC = 1'b1
  } mode_e;

  localparam int HDR_WORDS = 4;

endpackage

// File: rtl/lfsr_step.sv
// Fibonacci-style LFSR keystream register
// Load seed, advance by one shift on enable
module lfsr_step #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             init_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] taps_i,
  output logic [WIDTH-1:0] state_o
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;

  // next state: shift left, feedback parity of tapped bits
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = seed_i;
    end else if (en_i) begin
      state_d = {state_q[WIDTH-2:0], ^(state_q & taps_i)};
    end
  end

  // state register
  always_ff @(posedge clk_i) begin
    if (init_i) state_q <= '0;
    else        state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/lfsr_codec.sv
// LFSR stream codec with padded preamble
// Reads header, writes/checks pad, then xors message
module lfsr_codec
  import lfsr_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int AW       = 8,
  parameter int HDR_BASE = 61,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 64,
  parameter logic [WIDTH-1:0] PAD_CHAR = WIDTH'(8'hA0)
) (
  input  logic             clk,
  input  logic             init,
  input  logic             start,
  input  logic             mode,
  output logic [AW-1:0]    mem_raddr,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [AW-1:0]    mem_waddr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_wen,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] taps_q, taps_d;
  logic [WIDTH-1:0] pad_q, pad_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             wen_q, wen_d;
  logic [AW-1:0]    waddr_q, waddr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;

  logic [AW-1:0]    raddr;
  logic             ks_ld;
  logic             ks_en;
  logic [WIDTH-1:0] ks;
  logic             fin;
  logic [WIDTH-1:0] km1;
  logic [AW-1:0]    kidx;
  logic [AW-1:0]    soff;
  logic [AW-1:0]    doff;
  logic [WIDTH-1:0] xr;

  lfsr_step #(.WIDTH(WIDTH)) u_step (
    .clk_i  (clk),
    .init_i (init),
    .load_i (ks_ld),
    .seed_i (mem_rdata),
    .en_i   (ks_en),
    .taps_i (taps_q),
    .state_o(ks)
  );

  // data for index cnt-1 arrives while cnt is issued
  assign km1  = cnt_q - 1'b1;
  assign kidx = AW'(km1);
  assign soff = (mode_q == ENC) ? '0 : AW'(pad_q);
  assign doff = (mode_q == ENC) ? AW'(pad_q) : '0;
  assign xr   = mem_rdata ^ ks;

  // next-state, read address and write staging
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    taps_d  = taps_q;
    pad_d   = pad_q;
    len_d   = len_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    raddr   = '0;
    ks_ld   = 1'b0;
    ks_en   = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode_e'(mode);
          done_d  = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        raddr = AW'(HDR_BASE) + AW'(cnt_q);
        cnt_d = cnt_q + 1'b1;
        unique case (1'b1)
          (cnt_q == WIDTH'(1)): ks_ld  = 1'b1;
          (cnt_q == WIDTH'(2)): taps_d = mem_rdata;
          (cnt_q == WIDTH'(3)): pad_d  = mem_rdata;
          (cnt_q == WIDTH'(HDR_WORDS)): begin
            len_d = mem_rdata;
            cnt_d = '0;
            if (ks == '0) begin
              err_d = 1'b1;
              fin   = 1'b1;
            end else if (pad_q != '0) begin
              state_d = S_PAD;
            end else if (mem_rdata != '0) begin
              state_d = S_XFER;
            end else begin
              fin = 1'b1;
            end
          end
          default: ;
        endcase
      end
      S_PAD: begin
        raddr = AW'(SRC_BASE) + AW'(cnt_q);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q != '0) begin
          ks_en = 1'b1;
          if (mode_q == ENC) begin
            wen_d   = 1'b1;
            waddr_d = AW'(DST_BASE) + kidx;
            wdata_d = PAD_CHAR ^ ks;
          end else if (xr != PAD_CHAR) begin
            err_d = 1'b1;
          end
          if (cnt_q == pad_q) begin
            cnt_d = '0;
            if (len_q != '0) state_d = S_XFER;
            else             fin     = 1'b1;
          end
        end
      end
      S_XFER: begin
        raddr = AW'(SRC_BASE) + soff + AW'(cnt_q);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q != '0) begin
          ks_en   = 1'b1;
          wen_d   = 1'b1;
          waddr_d = AW'(DST_BASE) + doff + kidx;
          wdata_d = xr;
          if (cnt_q == len_q) begin
            cnt_d = '0;
            fin   = 1'b1;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (fin) begin
      state_d = S_FIN;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (init) begin
      state_q <= S_IDLE;
      mode_q  <= ENC;
      cnt_q   <= '0;
      taps_q  <= '0;
      pad_q   <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      taps_q  <= taps_d;
      pad_q   <= pad_d;
      len_q   <= len_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_raddr = raddr;
  assign mem_waddr = waddr_q;
  assign mem_wdata = wdata_q;
  assign mem_wen   = wen_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_lfsr_codec.sv
// lfsr_codec directed bench
// Encoder instance A, decoder instance B, own memories
module tb_lfsr_codec;

  logic clk = 1'b0;
  logic init;
  logic a_start, a_mode, b_start, b_mode;
  logic [7:0] a_raddr, a_rdata, a_waddr, a_wdata;
  logic [7:0] b_raddr, b_rdata, b_waddr, b_wdata;
  logic a_wen, a_busy, a_done, a_err;
  logic b_wen, b_busy, b_done, b_err;
  logic [7:0] mem_a [0:255];
  logic [7:0] mem_b [0:255];
  int a_wcnt = 0;
  int b_wcnt = 0;
  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  lfsr_codec dut_a (
    .clk(clk), .init(init),
    .start(a_start), .mode(a_mode),
    .mem_raddr(a_raddr), .mem_rdata(a_rdata),
    .mem_waddr(a_waddr), .mem_wdata(a_wdata),
    .mem_wen(a_wen), .busy(a_busy),
    .done(a_done), .err(a_err)
  );

  lfsr_codec #(
    .HDR_BASE(32), .SRC_BASE(64), .DST_BASE(128)
  ) dut_b (
    .clk(clk), .init(init),
    .start(b_start), .mode(b_mode),
    .mem_raddr(b_raddr), .mem_rdata(b_rdata),
    .mem_waddr(b_waddr), .mem_wdata(b_wdata),
    .mem_wen(b_wen), .busy(b_busy),
    .done(b_done), .err(b_err)
  );

  always @(posedge clk) begin
    a_rdata <= mem_a[a_raddr];
    if (a_wen) begin
      mem_a[a_waddr] = a_wdata;
      a_wcnt++;
    end
  end

  always @(posedge clk) begin
    b_rdata <= mem_b[b_raddr];
    if (b_wen) begin
      mem_b[b_waddr] = b_wdata;
      b_wcnt++;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic hdr_a(input logic [7:0] s, t, p, l);
    mem_a[61] = s;
    mem_a[62] = t;
    mem_a[63] = p;
    mem_a[64] = l;
  endtask

  task automatic hdr_b(input logic [7:0] s, t, p, l);
    mem_b[32] = s;
    mem_b[33] = t;
    mem_b[34] = p;
    mem_b[35] = l;
  endtask

  task automatic run(input bit use_b, input logic m,
                     output int cyc, output logic bsy1);
    cyc  = -1;
    bsy1 = 1'b0;
    @(negedge clk);
    if (use_b) begin
      b_mode  = m;
      b_start = 1'b1;
    end else begin
      a_mode  = m;
      a_start = 1'b1;
    end
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i == 1) begin
        a_start = 1'b0;
        b_start = 1'b0;
        bsy1 = use_b ? b_busy : a_busy;
      end
      if (use_b ? b_done : a_done) begin
        cyc = i;
        break;
      end
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    int w0;
    logic bsy1;
    logic seen;
    init    = 1'b1;
    a_start = 1'b0;
    b_start = 1'b0;
    a_mode  = 1'b0;
    b_mode  = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_done", a_done, 1'b0);
    chk("rst_err", a_err, 1'b0);
    chk("rst_wen", a_wen, 1'b0);
    chk("rst_raddr", a_raddr, 8'h00);
    chk("rst_waddr", a_waddr, 8'h00);
    init = 1'b0;

    // encode: seed 01 taps B8 P=2 L=1
    hdr_a(8'h01, 8'hB8, 8'h02, 8'h01);
    mem_a[0] = 8'h48;
    w0 = a_wcnt;
    run(1'b0, 1'b0, cyc, bsy1);
    chk("enc_busy1", bsy1, 1'b1);
    chk("enc_finished", cyc > 0, 1'b1);
    chk("enc_d64", mem_a[64], 8'hA1);
    chk("enc_d65", mem_a[65], 8'hA2);
    chk("enc_d66", mem_a[66], 8'h4C);
    chk("enc_done", a_done, 1'b1);
    chk("enc_err", a_err, 1'b0);
    chk("enc_busy", a_busy, 1'b0);
    chk("enc_nwr", a_wcnt - w0, 3);

    // decode of the encoded stream
    hdr_b(8'h01, 8'hB8, 8'h02, 8'h01);
    mem_b[64]  = 8'hA1;
    mem_b[65]  = 8'hA2;
    mem_b[66]  = 8'h4C;
    mem_b[128] = 8'h00;
    w0 = b_wcnt;
    run(1'b1, 1'b1, cyc, bsy1);
    chk("dec_finished", cyc > 0, 1'b1);
    chk("dec_d128", mem_b[128], 8'h48);
    chk("dec_err", b_err, 1'b0);
    chk("dec_done", b_done, 1'b1);
    chk("dec_nwr", b_wcnt - w0, 1);

    // corrupted pad byte
    mem_b[64]  = 8'hA3;
    mem_b[128] = 8'h00;
    run(1'b1, 1'b1, cyc, bsy1);
    chk("bad_finished", cyc > 0, 1'b1);
    chk("bad_err", b_err, 1'b1);
    chk("bad_done", b_done, 1'b1);
    chk("bad_d128", mem_b[128], 8'h48);

    // seed zero lockup
    hdr_a(8'h00, 8'hB8, 8'h02, 8'h01);
    w0 = a_wcnt;
    run(1'b0, 1'b0, cyc, bsy1);
    chk("s0_finished", cyc > 0, 1'b1);
    chk("s0_err", a_err, 1'b1);
    chk("s0_done", a_done, 1'b1);
    chk("s0_nwr", a_wcnt - w0, 0);

    // empty job
    hdr_a(8'h01, 8'hB8, 8'h00, 8'h00);
    w0 = a_wcnt;
    run(1'b0, 1'b0, cyc, bsy1);
    chk("empty_lat", cyc >= 1 && cyc <= 6, 1'b1);
    chk("empty_done", a_done, 1'b1);
    chk("empty_err", a_err, 1'b0);
    chk("empty_nwr", a_wcnt - w0, 0);

    // init pulsed during transfer
    hdr_a(8'h01, 8'hB8, 8'h00, 8'h08);
    for (int i = 0; i < 8; i++) mem_a[i] = 8'(i + 16);
    @(negedge clk);
    a_mode  = 1'b0;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (a_wen) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("abort_wen_seen", seen, 1'b1);
    init = 1'b1;
    @(negedge clk);
    chk("abort_busy", a_busy, 1'b0);
    chk("abort_wen", a_wen, 1'b0);
    init = 1'b0;
    w0 = a_wcnt;
    repeat (5) @(negedge clk);
    chk("abort_nwr", a_wcnt - w0, 0);

    // clean encode after abort
    hdr_a(8'h01, 8'hB8, 8'h02, 8'h01);
    mem_a[0]  = 8'h48;
    mem_a[65] = 8'h00;
    mem_a[66] = 8'h00;
    run(1'b0, 1'b0, cyc, bsy1);
    chk("re_finished", cyc > 0, 1'b1);
    chk("re_d64", mem_a[64], 8'hA1);
    chk("re_d65", mem_a[65], 8'hA2);
    chk("re_d66", mem_a[66], 8'h4C);
    chk("re_done", a_done, 1'b1);
    chk("re_err", a_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
